// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Ports: clk, rst (sync, active-high), req/req_data from requesters,
//   grant/done/err per-requester, tx_data/tx_start/tx_done to uart_tx, busy.
module uart_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   grant,
   output logic [NUM_REQ-1:0]   done,
   output logic [NUM_REQ-1:0]   err,
   output logic [7:0]           tx_data,
   output logic                 tx_start,
   input  logic                 tx_done,
   output logic                 busy
);

   localparam int LW = $clog2(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT,
      DONE
   } state_t;

   state_t        state;
   logic [LW-1:0] last;
   logic [LW-1:0] win;
   logic [CW-1:0] cnt;
   logic [LW:0]   idx;
   logic          found;

   // Search upward from last+1 with wrap; the extra idx bit
   // holds last+k before it is folded back into range.
   always_comb begin
      win   = last;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = {1'b0, last} + (LW+1)'(k);
         if (idx >= (LW+1)'(NUM_REQ))
            idx = idx - (LW+1)'(NUM_REQ);
         if (!found && req[idx[LW-1:0]]) begin
            found = 1'b1;
            win   = idx[LW-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= '0;
         done     <= '0;
         err      <= '0;
         tx_data  <= 8'h00;
         tx_start <= 1'b0;
         cnt      <= '0;
         last     <= LW'(NUM_REQ-1);
      end else begin
         done     <= '0;
         err      <= '0;
         tx_start <= 1'b0;
         unique case (state)
            IDLE: begin
               if (found) begin
                  state    <= START;
                  grant    <= NUM_REQ'(1) << win;
                  tx_data  <= req_data[{win, 3'b000} +: 8];
                  last     <= win;
                  tx_start <= 1'b1;
               end
            end
            START: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               // tx_done is tested first so a completion on the
               // final timeout cycle still counts as success.
               if (tx_done) begin
                  state <= DONE;
                  done  <= grant;
               end else if (cnt == CW'(TIMEOUT-1)) begin
                  state <= DONE;
                  err   <= grant;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               grant <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT=8).
// Ports: drives every DUT port; prints one TB_RESULT summary line.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic [3:0]  err;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        tx_done;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   uart_tx_arbiter #(
      .NUM_REQ(4),
      .TIMEOUT(8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
      .grant    (grant),
      .done     (done),
      .err      (err),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .tx_done  (tx_done),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_reset(input string tag);
      chk({tag, "_grant"}, 32'(grant), 32'h0);
      chk({tag, "_done"}, 32'(done), 32'h0);
      chk({tag, "_err"}, 32'(err), 32'h0);
      chk({tag, "_start"}, 32'(tx_start), 32'h0);
      chk({tag, "_data"}, 32'(tx_data), 32'h0);
      chk({tag, "_busy"}, 32'(busy), 32'h0);
   endtask

   initial begin
      rst      = 1'b1;
      req      = 4'b0000;
      req_data = 32'h0;
      tx_done  = 1'b0;
      tick();
      tick();
      chk_idle_reset("rst");

      // single request from requester 2, dropped after grant
      rst      = 1'b0;
      req      = 4'b0100;
      req_data = 32'h44A52211;
      tick();
      chk("s_grant", 32'(grant), 32'h4);
      chk("s_data", 32'(tx_data), 32'hA5);
      chk("s_start", 32'(tx_start), 32'h1);
      chk("s_busy", 32'(busy), 32'h1);
      req = 4'b0000;
      tick();
      chk("s_start_lo", 32'(tx_start), 32'h0);
      chk("s_grant_w", 32'(grant), 32'h4);
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("s_done", 32'(done), 32'h4);
      chk("s_err", 32'(err), 32'h0);
      chk("s_grant_d", 32'(grant), 32'h4);
      tick();
      chk("s_done_lo", 32'(done), 32'h0);
      chk("s_grant_lo", 32'(grant), 32'h0);
      chk("s_busy_lo", 32'(busy), 32'h0);

      // round robin from fresh reset: 0,1,2,3,0 back to back
      rst = 1'b1;
      tick();
      rst      = 1'b0;
      req      = 4'b1111;
      req_data = 32'hD3C2B1A0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rr_grant", 32'(grant), 32'(1) << (i % 4));
         chk("rr_data", 32'(tx_data), 32'hA0 + 32'h11 * (i % 4));
         chk("rr_start", 32'(tx_start), 32'h1);
         tick();
         tick();
         tick();
         tx_done = 1'b1;
         tick();
         tx_done = 1'b0;
         chk("rr_done", 32'(done), 32'(1) << (i % 4));
         tick();
         chk("rr_idle", 32'(grant), 32'h0);
      end
      req = 4'b0000;

      // timeout abort on requester 0 (last served was 0)
      req      = 4'b0001;
      req_data = 32'h0000005A;
      tick();
      chk("to_grant", 32'(grant), 32'h1);
      req = 4'b0000;
      tick();
      for (int i = 0; i < 7; i++) tick();
      chk("to_early_err", 32'(err), 32'h0);
      chk("to_early_busy", 32'(busy), 32'h1);
      tick();
      chk("to_err", 32'(err), 32'h1);
      chk("to_done", 32'(done), 32'h0);
      tick();
      chk("to_err_lo", 32'(err), 32'h0);
      chk("to_busy_lo", 32'(busy), 32'h0);

      // tx_done on the last timeout cycle: success wins
      req = 4'b0001;
      tick();
      chk("co_grant", 32'(grant), 32'h1);
      req = 4'b0000;
      tick();
      for (int i = 0; i < 7; i++) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("co_done", 32'(done), 32'h1);
      chk("co_err", 32'(err), 32'h0);
      tick();

      // data held while requester rewrites its byte
      req      = 4'b0010;
      req_data = 32'h00003C00;
      tick();
      chk("dh_grant", 32'(grant), 32'h2);
      chk("dh_data0", 32'(tx_data), 32'h3C);
      req = 4'b0000;
      tick();
      req_data = 32'h0000FF00;
      tick();
      chk("dh_data1", 32'(tx_data), 32'h3C);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("dh_data2", 32'(tx_data), 32'h3C);
      chk("dh_done", 32'(done), 32'h2);
      tick();

      // reset mid-WAIT, stale tx_done, pointer back to requester 0
      req = 4'b0010;
      tick();
      chk("mr_grant", 32'(grant), 32'h2);
      req = 4'b0000;
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk_idle_reset("mr");
      rst     = 1'b0;
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("mr_stale_done", 32'(done), 32'h0);
      chk("mr_stale_busy", 32'(busy), 32'h0);
      req = 4'b0110;
      tick();
      chk("mr_ptr_grant", 32'(grant), 32'h2);
      req = 4'b0000;
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      chk("mr_done", 32'(done), 32'h2);
      tick();
      chk("mr_end_busy", 32'(busy), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one UART transmitter (legal 2..8).
REQ-002 Parameter TIMEOUT, default 1024, max WAIT-state cycles for tx_done before abort (legal >= 2).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  NUM_REQ  per-requester transmit request, level.
REQ-006 req_data  input  8*NUM_REQ  byte from requester i at bits [8i+7:8i].
REQ-007 grant  output  NUM_REQ  one-hot owner of transmitter, registered.
REQ-008 done  output  NUM_REQ  one-cycle pulse to owner: byte sent OK.
REQ-009 err  output  NUM_REQ  one-cycle pulse to owner: timeout abort.
REQ-010 tx_data  output  8  byte to uart_tx data input, registered.
REQ-011 tx_start  output  1  one-cycle start strobe to uart_tx, registered.
REQ-012 tx_done  input  1  completion pulse from uart_tx.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states SHALL be IDLE, START, WAIT, DONE; only transitions: IDLE->START, START->WAIT, WAIT->DONE, DONE->IDLE, any->IDLE on rst.
REQ-015 IDLE: if any req bit high, select winner by round-robin, searching from index (last+1) mod NUM_REQ upward with wrap; go to START; else stay.
REQ-016 On selection edge: grant <= one-hot(winner), tx_data <= req_data slice of winner, last <= winner.
REQ-017 Request in IDLE cycle t -> grant and tx_start high in cycle t+1 (1-cycle latency); tx_start high only in START.
REQ-018 tx_data and winner SHALL be held constant from START through DONE; req_data changes after selection ignored.
REQ-019 START: clear timeout counter; tx_done ignored in this state.
REQ-020 WAIT: counter increments each cycle; tx_done high -> DONE with ok flag; counter reaching TIMEOUT-1 without tx_done -> DONE with err flag; tx_done and timeout in same cycle -> ok wins.
REQ-021 DONE: exactly one of done[winner] or err[winner] high for this single cycle; grant stays high in DONE, all-zero from next cycle.
REQ-022 Requester dropping req mid-transfer SHALL NOT abort it; done/err still pulsed.
REQ-023 Requester still asserting req after done re-arbitrates in next IDLE; round-robin guarantees each other pending requester is served before repeat.
REQ-024 Back-to-back throughput: DONE cycle k -> IDLE k+1 -> next tx_start at k+2 if any req pending.
REQ-025 grant, done, err SHALL each be one-hot or zero every cycle; done and err never both high.
REQ-026 Counter width $clog2(TIMEOUT); no wrap possible before timeout fires.

Reset
REQ-027 rst high at an edge: state IDLE, grant 0, done 0, err 0, tx_start 0, tx_data 8'h00, busy 0, counter 0, last NUM_REQ-1 (requester 0 first priority).
REQ-028 rst mid-transfer: abort without done/err pulse; tx_start low from next cycle; stale tx_done after reset ignored (IDLE).

Verification
REQ-029 Single: req=4'b0100, data[2]=8'hA5 at t -> grant=4'b0100, tx_data=8'hA5, tx_start=1 at t+1 only; tx_done pulse -> done=4'b0100 one cycle later, grant 0 cycle after.
REQ-030 Round-robin: req=4'b1111 held, tx_done 3 cycles after each tx_start -> grant order 0,1,2,3,0; tx_data matches each slice.
REQ-031 Timeout: TIMEOUT=8, req=4'b0001, tx_done never -> err=4'b0001 pulse, done stays 0, FSM back to IDLE; next request served normally.
REQ-032 Collision: tx_done on same cycle as counter=TIMEOUT-1 -> done pulse, no err.
REQ-033 Mid-op reset: rst during WAIT for requester 1 -> all outputs at reset values next cycle, no done/err; subsequent req=4'b0010 granted with requester-0 priority pointer.
REQ-034 Data hold: change req_data[1] from 8'h3C to 8'hFF during WAIT -> tx_data stays 8'h3C through DONE.
